codec_sample_capture: RTL and testbench
=======================================

# codec_sample_capture

Receive-side counterpart of the playback path: while the player pushes one sample to the codec per `new_frame`, this block pulls one 16-bit sample from the codec's capture path per `new_frame`. It decimates, buffers samples in a small FIFO, and presents them downstream (waveform display, recorder) through a valid/ready handshake. It sits between `ac97_if` and any sample consumer. It is controlled by one-pulsed start/stop inputs from the MCU.

## Interface

Parameters:
- `DEPTH`, 16: FIFO depth in samples. Must be a power of two, ≥ 2.
- `DECIM`, 1: keep one of every `DECIM` frame events. Range 1..255.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `new_frame`  in  1  raw frame signal from `ac97_if`; may stay high for several cycles.
- `sample_in`  in  16  signed ADC sample from `ac97_if`; valid whenever `new_frame` is high.
- `start`  in  1  one-cycle pulse that begins capture.
- `stop`  in  1  one-cycle pulse that ends capture.
- `sample_ready`  in  1  downstream accepts `sample_out` this cycle.
- `sample_out`  out  16  oldest buffered sample.
- `sample_valid`  out  1  `sample_out` is valid.
- `fifo_count`  out  $clog2(DEPTH)+1  number of samples held.
- `capturing`  out  1  FSM is in RUN.
- `overflow_count`  out  8  number of dropped samples; saturates at 255.

## Operation

- Frame event: `frame_edge = new_frame & ~new_frame_q`, where `new_frame_q` is the registered copy of `new_frame`. There is exactly one event per frame.
- FSM states:
  - IDLE: start pulse → RUN.
  - RUN: stop pulse → IDLE.
  - If `start` and `stop` are high in the same cycle, `stop` wins and the state goes to (or stays in) IDLE.
  - `capturing` = (state == RUN).
- Decimation counter, 8 bits:
  - Cleared when entering RUN.
  - In RUN, on each `frame_edge`: if counter == 0 the event is *qualified*; the counter then loads `DECIM-1`, otherwise it decrements.
  - The first frame after `start` is therefore always qualified.
  - `DECIM=1` qualifies every frame.
- Push: a qualified event writes `sample_in` as sampled in the `frame_edge` cycle.
  - Not full → stored.
  - Full and no pop in the same cycle → the new sample is dropped and `overflow_count` increments, saturating at 255. FIFO contents are unchanged.
  - Full with a simultaneous pop → push is accepted and there is no overflow.
- Pop: occurs when `sample_valid & sample_ready`.
  - `sample_ready` with an empty FIFO has no effect.
- Output: the FIFO is first-word fall-through. `sample_out` always shows the head entry; `sample_valid = (fifo_count != 0)`.
- Leaving RUN does not flush the FIFO. Buffered samples remain poppable in IDLE, and no pushes occur in IDLE.
- `overflow_count` clears only on reset.
- Arithmetic:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Count is one bit wider.
  - Samples are stored bit-exact, with no scaling or sign change.

## Timing

- Reset values:
  - state IDLE, `capturing` 0.
  - `sample_valid` 0, `fifo_count` 0, `sample_out` 16'h0000.
  - `overflow_count` 0, `new_frame_q` 0, decimation counter 0.
- Reset mid-capture flushes the FIFO and returns to IDLE in the same edge.
- `start` at edge N → `capturing` = 1 after edge N. A `frame_edge` in cycle N+1 is the first one that can push.
- Push latency: `frame_edge` in cycle N into an empty FIFO → `sample_valid` = 1 and `sample_out` = the sample after edge N (visible in cycle N+1).
- Pop: handshake in cycle N → head advances and `fifo_count` decrements after edge N.
- Simultaneous push and pop: `fifo_count` is unchanged.
  - When the FIFO held one entry, `sample_out` shows the new sample in N+1.
- `stop` in the same cycle as a `frame_edge`: the push is still performed, because the qualification uses the pre-edge state.
- `new_frame` held high for k cycles produces one event. It must drop low for at least one cycle before another event can occur.

## Structure

- Shared header `capture_defs.vh`: FSM state encodings (`CAP_IDLE`, `CAP_RUN`) and the overflow saturation constant 8'd255.
- One sub-module, `sync_fifo`, parameterised by `WIDTH` and `DEPTH`. It is FWFT with push/pop/full/empty/count and holds the pointer and count logic.
- The top level holds the edge detector, FSM, decimation counter, overflow counter, and drop logic.

## Test plan

- Reset then `start`; 3 frames carrying 16'h0001, 16'h8000, 16'h7FFF; `sample_ready`=1 → the outputs are popped in that order, each with `sample_valid` high for exactly 1 cycle, and `fifo_count` returns to 0.
- `new_frame` held high for 5 cycles with `sample_in`=16'h1234 → exactly one push and `fifo_count`=1.
- `DECIM`=4, 12 frames with values 0..11, then drain → the output sequence is 0, 4, 8.
- `DEPTH`=16, `sample_ready`=0, 20 frames with values 0..19 → `fifo_count`=16 and `overflow_count`=4; draining yields 0..15. With 300 frames held off, `overflow_count` saturates at 255.
- FIFO full, with `frame_edge` and a pop in the same cycle → `overflow_count` is unchanged, `fifo_count` stays 16, and the new sample is the last one out.
- `stop` mid-capture with 5 samples buffered, then further frames → no pushes occur and all 5 samples still drain. `reset` asserted with 5 samples buffered → `fifo_count`=0, `sample_valid`=0 and `capturing`=0 the next cycle.

Source files
------------

// File: rtl/codec_sample_capture_pkg.sv
// Shared definitions for the codec capture path: FSM states and overflow saturation value.
package codec_sample_capture_pkg;

  typedef enum logic [0:0] {
    CapIdle = 1'b0,
    CapRun  = 1'b1
  } cap_state_e;

  localparam logic [7:0] OvfSat = 8'd255;

endpackage

// File: rtl/codec_sample_capture_sync_fifo.sv
// First-word fall-through FIFO; a push into a full FIFO is accepted only alongside a pop.
module codec_sample_capture_sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  assign pop_ok  = pop_i & ~empty_o;
  // Full is fine when the head leaves in the same cycle: the write lands in the freed slot.
  assign push_ok = push_i & (~full_o | pop_ok);

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/codec_sample_capture.sv
// Pulls one ADC sample per (decimated) codec frame into a FIFO and offers it downstream
// through a valid/ready handshake while the MCU-controlled capture FSM is running.
module codec_sample_capture
  import codec_sample_capture_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned DECIM = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   new_frame,
  input  logic [15:0]            sample_in,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   sample_ready,
  output logic [15:0]            sample_out,
  output logic                   sample_valid,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   capturing,
  output logic [7:0]             overflow_count
);

  localparam logic [7:0] DecimReload = 8'(DECIM - 1);

  cap_state_e state_q, state_d;
  logic       new_frame_q;
  logic [7:0] decim_q, decim_d;
  logic [7:0] ovf_q, ovf_d;
  logic       frame_edge, running, qualified, pop, drop;
  logic       fifo_full, fifo_empty;

  assign frame_edge = new_frame & ~new_frame_q;
  assign running    = (state_q == CapRun);
  // Qualification looks at the pre-edge state, so a stop coinciding with a frame still pushes.
  assign qualified  = running & frame_edge & (decim_q == 8'd0);
  assign pop        = sample_valid & sample_ready;
  assign drop       = qualified & fifo_full & ~pop;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CapIdle: if (start && !stop) state_d = CapRun;
      CapRun:  if (stop) state_d = CapIdle;
      default: state_d = CapIdle;
    endcase
  end

  always_comb begin
    decim_d = decim_q;
    if (state_q == CapIdle && state_d == CapRun) begin
      decim_d = 8'd0;
    end else if (running && frame_edge) begin
      decim_d = (decim_q == 8'd0) ? DecimReload : decim_q - 8'd1;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (drop && ovf_q != OvfSat) begin
      ovf_d = ovf_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CapIdle;
      new_frame_q <= 1'b0;
      decim_q     <= 8'd0;
      ovf_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      new_frame_q <= new_frame;
      decim_q     <= decim_d;
      ovf_q       <= ovf_d;
    end
  end

  codec_sample_capture_sync_fifo #(
    .WIDTH (16),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .reset_i (reset),
    .push_i  (qualified),
    .wdata_i (sample_in),
    .pop_i   (pop),
    .rdata_o (sample_out),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign sample_valid   = ~fifo_empty;
  assign capturing      = running;
  assign overflow_count = ovf_q;

endmodule

// File: tb/tb_codec_sample_capture.sv
// Bench for codec_sample_capture: directed table/sequences plus random traffic vs a queue model.
module tb_codec_sample_capture;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset, new_frame, start, stop, sample_ready;
  logic [15:0] sample_in;
  logic [15:0] out0, out1;
  logic        v0, v1, cap0, cap1;
  logic [4:0]  c0, c1;
  logic [7:0]  ov0, ov1;

  always #5 clk = ~clk;

  codec_sample_capture #(.DEPTH(DEPTH), .DECIM(1)) dut (
    .clk(clk), .reset(reset), .new_frame(new_frame), .sample_in(sample_in), .start(start),
    .stop(stop), .sample_ready(sample_ready), .sample_out(out0), .sample_valid(v0),
    .fifo_count(c0), .capturing(cap0), .overflow_count(ov0)
  );

  codec_sample_capture #(.DEPTH(DEPTH), .DECIM(4)) dut4 (
    .clk(clk), .reset(reset), .new_frame(new_frame), .sample_in(sample_in), .start(start),
    .stop(stop), .sample_ready(sample_ready), .sample_out(out1), .sample_valid(v1),
    .fifo_count(c1), .capturing(cap1), .overflow_count(ov1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: a running flag, a frame index since start and a bounded sample list.
  bit          m_run [2];
  bit          m_pnf [2];
  int          m_fidx[2];
  int          m_head[2];
  int          m_cnt [2];
  int          m_ovf [2];
  int          m_decim[2];
  logic [15:0] m_data[2][64];

  logic [15:0] got[$];

  typedef struct {
    logic        nf;
    logic [15:0] din;
    logic        st;
    logic        rdy;
    logic        ev;
    logic [15:0] eo;
    logic [4:0]  ec;
    logic        ecap;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_step(input int i);
    bit edge_ev, pop, push;
    int pre;
    if (reset) begin
      m_run[i] = 0; m_pnf[i] = 0; m_fidx[i] = 0; m_head[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0;
      return;
    end
    pre     = m_cnt[i];
    edge_ev = new_frame && !m_pnf[i];
    pop     = (pre > 0) && sample_ready;
    push    = 0;
    if (m_run[i] && edge_ev) begin
      push = (m_fidx[i] % m_decim[i]) == 0;
      m_fidx[i]++;
    end
    if (pop) begin
      m_head[i] = (m_head[i] + 1) % 64;
      m_cnt[i]--;
    end
    if (push) begin
      if (pre < DEPTH || pop) begin
        m_data[i][(m_head[i] + m_cnt[i]) % 64] = sample_in;
        m_cnt[i]++;
      end else if (m_ovf[i] < 255) begin
        m_ovf[i]++;
      end
    end
    if (stop) m_run[i] = 0;
    else if (start && !m_run[i]) begin
      m_run[i]  = 1;
      m_fidx[i] = 0;
    end
    m_pnf[i] = new_frame;
  endtask

  task automatic model_cmp(input int i, input logic cap, input logic v, input logic [4:0] c,
                           input logic [15:0] o, input logic [7:0] ov);
    logic [63:0] e, a;
    logic        ev;
    ev = (m_cnt[i] > 0);
    e  = 64'({m_run[i], ev, 8'(m_cnt[i]), (ev ? m_data[i][m_head[i]] : 16'h0), 8'(m_ovf[i])});
    a  = 64'({cap, v, 8'(c), (v ? o : 16'h0), ov});
    chk($sformatf("model%0d", i), a, e);
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    model_cmp(0, cap0, v0, c0, out0, ov0);
    model_cmp(1, cap1, v1, c1, out1, ov1);
  endtask

  task automatic frame(input logic [15:0] d);
    new_frame = 1'b1; sample_in = d; tick();
    new_frame = 1'b0; tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; new_frame = 1'b0; start = 1'b0; stop = 1'b0; sample_ready = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  // Pops instance i until empty, recording each popped sample.
  task automatic drain(input int i);
    got.delete();
    sample_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!(i == 0 ? v0 : v1)) break;
      got.push_back(i == 0 ? out0 : out1);
      tick();
    end
    chk("drain_done", 64'(i == 0 ? v0 : v1), 64'(0));
    sample_ready = 1'b0;
  endtask

  initial begin
    m_decim[0] = 1;
    m_decim[1] = 4;
    sample_in  = 16'h0;
    do_reset();
    chk("reset_out", 64'(out0), 64'(0));
    chk("reset_valid", 64'(v0), 64'(0));
    chk("reset_count", 64'(c0), 64'(0));
    chk("reset_cap", 64'(cap0), 64'(0));
    chk("reset_ovf", 64'(ov0), 64'(0));

    // Three frames popped as they arrive; each is valid for exactly one cycle.
    tbl[0] = '{nf:0, din:16'h0000, st:1, rdy:1, ev:0, eo:16'h0000, ec:0, ecap:1};
    tbl[1] = '{nf:1, din:16'h0001, st:0, rdy:1, ev:1, eo:16'h0001, ec:1, ecap:1};
    tbl[2] = '{nf:0, din:16'h0000, st:0, rdy:1, ev:0, eo:16'h0000, ec:0, ecap:1};
    tbl[3] = '{nf:1, din:16'h8000, st:0, rdy:1, ev:1, eo:16'h8000, ec:1, ecap:1};
    tbl[4] = '{nf:0, din:16'h0000, st:0, rdy:1, ev:0, eo:16'h0000, ec:0, ecap:1};
    tbl[5] = '{nf:1, din:16'h7FFF, st:0, rdy:1, ev:1, eo:16'h7FFF, ec:1, ecap:1};
    tbl[6] = '{nf:0, din:16'h0000, st:0, rdy:1, ev:0, eo:16'h0000, ec:0, ecap:1};
    for (int r = 0; r < 7; r++) begin
      new_frame = tbl[r].nf; sample_in = tbl[r].din; start = tbl[r].st;
      sample_ready = tbl[r].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", r), 64'(v0), 64'(tbl[r].ev));
      chk($sformatf("tbl%0d_count", r), 64'(c0), 64'(tbl[r].ec));
      chk($sformatf("tbl%0d_cap", r), 64'(cap0), 64'(tbl[r].ecap));
      if (tbl[r].ev) chk($sformatf("tbl%0d_out", r), 64'(out0), 64'(tbl[r].eo));
    end
    start = 1'b0; new_frame = 1'b0; sample_ready = 1'b0;

    // new_frame held high for several cycles is one event.
    do_reset(); pulse_start();
    new_frame = 1'b1; sample_in = 16'h1234;
    repeat (5) tick();
    new_frame = 1'b0; tick();
    chk("held_count", 64'(c0), 64'(1));
    chk("held_out", 64'(out0), 64'(16'h1234));

    // Decimation by 4 keeps frames 0, 4, 8.
    do_reset(); pulse_start();
    for (int k = 0; k < 12; k++) frame(16'(k));
    chk("decim_count", 64'(c1), 64'(3));
    drain(1);
    chk("decim_len", 64'(got.size()), 64'(3));
    for (int k = 0; k < 3 && k < got.size(); k++)
      chk($sformatf("decim_val%0d", k), 64'(got[k]), 64'(4 * k));

    // Overflow with the consumer stalled, then saturation.
    do_reset(); pulse_start();
    for (int k = 0; k < 20; k++) frame(16'(k));
    chk("ovf_count", 64'(c0), 64'(16));
    chk("ovf_drops", 64'(ov0), 64'(4));
    drain(0);
    chk("ovf_len", 64'(got.size()), 64'(16));
    for (int k = 0; k < 16 && k < got.size(); k++)
      chk($sformatf("ovf_val%0d", k), 64'(got[k]), 64'(k));
    for (int k = 0; k < 300; k++) frame(16'(k));
    chk("ovf_sat", 64'(ov0), 64'(255));

    // Full FIFO with push and pop together: no drop, count holds, new sample comes out last.
    do_reset(); pulse_start();
    for (int k = 0; k < 16; k++) frame(16'(100 + k));
    chk("fullpop_pre", 64'(c0), 64'(16));
    sample_ready = 1'b1; new_frame = 1'b1; sample_in = 16'hBEEF;
    tick();
    new_frame = 1'b0;
    chk("fullpop_count", 64'(c0), 64'(16));
    chk("fullpop_ovf", 64'(ov0), 64'(0));
    drain(0);
    chk("fullpop_len", 64'(got.size()), 64'(16));
    if (got.size() > 0) chk("fullpop_last", 64'(got[got.size() - 1]), 64'(16'hBEEF));

    // Stop keeps buffered samples and blocks further pushes.
    do_reset(); pulse_start();
    for (int k = 0; k < 5; k++) frame(16'(200 + k));
    pulse_stop();
    for (int k = 0; k < 3; k++) frame(16'(300 + k));
    chk("stop_count", 64'(c0), 64'(5));
    chk("stop_cap", 64'(cap0), 64'(0));
    drain(0);
    chk("stop_len", 64'(got.size()), 64'(5));
    for (int k = 0; k < 5 && k < got.size(); k++)
      chk($sformatf("stop_val%0d", k), 64'(got[k]), 64'(200 + k));

    // Stop in the same cycle as a frame edge still pushes.
    pulse_start();
    new_frame = 1'b1; stop = 1'b1; sample_in = 16'h5A5A;
    tick();
    new_frame = 1'b0; stop = 1'b0;
    chk("stopedge_count", 64'(c0), 64'(1));
    chk("stopedge_cap", 64'(cap0), 64'(0));

    // Reset mid-capture flushes.
    do_reset(); pulse_start();
    for (int k = 0; k < 5; k++) frame(16'(k + 1));
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_count", 64'(c0), 64'(0));
    chk("rst_valid", 64'(v0), 64'(0));
    chk("rst_cap", 64'(cap0), 64'(0));
    chk("rst_out", 64'(out0), 64'(0));

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset        = ($urandom_range(499) == 0);
      start        = ($urandom_range(19) == 0);
      stop         = ($urandom_range(59) == 0);
      new_frame    = ($urandom_range(9) < 4);
      sample_in    = 16'($urandom);
      sample_ready = ($urandom_range(2) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
